vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the 640x480 VGA timing generator.
- Samples an incoming VGA stream (active-low HS/VS plus 3-bit RGB) on a pixel strobe and recovers pixel coordinates and data-enable.
- Measures line and frame length, and declares lock once timing matches the 640x480@800x521 format.
- Used for loopback checking of the video path and for capturing external VGA-format sources.

Parameters:
- H_TOTAL, 800: samples per line.
- H_SYNC, 96: HS low width in samples.
- H_BP, 48: horizontal back porch.
- H_DISP, 640: active pixels per line.
- V_TOTAL, 521: lines per frame.
- V_SYNC, 2: VS low width in lines.
- V_BP, 29: vertical back porch.
- V_DISP, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive clean frames required to assert lock.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- pix_ce, input, 1: pixel sample strobe; all state advances only on clk edges with pix_ce=1.
- vga_hs, input, 1: horizontal sync, active low.
- vga_vs, input, 1: vertical sync, active low.
- vga_rgb, input, 3: incoming colour.
- rgb_out, output, 3: registered colour; 0 when de=0.
- de, output, 1: active-pixel flag.
- vga_xypos, output, 21: {x[10:0], y[9:0]}; valid only when de=1.
- locked, output, 1: timing lock.
- sync_err, output, 1: one-clk pulse on any timing violation.
- line_len, output, 10: sample count of the last completed line.
- frame_lines, output, 10: line count of the last completed frame.

Behaviour:
- Reset (synchronous, active-high): hs_d=1, vs_d=1, h_cnt=0, v_cnt=0, state=SEARCH, good_cnt=0, frame_bad=0. Outputs: rgb_out=0, de=0, vga_xypos=0, locked=0, sync_err=0, line_len=0, frame_lines=0.
- Sync edge detection, evaluated on pix_ce ticks only; hs_d/vs_d load the current sync inputs on every pix_ce tick:
  - hs_fall = hs_d & ~vga_hs; hs_rise = ~hs_d & vga_hs; vs_fall = vs_d & ~vga_vs.
- h_cnt (10b), on pix_ce: hs_fall -> 0; else increment, saturating at 1023.
- v_cnt (10b), on pix_ce: vs_fall -> 0 (vs_fall has priority when it coincides with hs_fall); else if hs_fall -> increment, saturating at 1023.
- Counter meaning: the sample where HS first reads low is h_cnt=0. The first line with VS low is v_cnt=0.
- Output registers, loaded on each pix_ce tick; latency is one pix_ce tick, aligned with the sample producing h_cnt/v_cnt:
  - de = locked & (H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_DISP) & (V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_DISP).
  - x = h_cnt-(H_SYNC+H_BP), 11-bit; y = v_cnt-(V_SYNC+V_BP), 10-bit.
  - rgb_out = de ? vga_rgb : 0.
- Measurement registers:
  - On hs_fall: line_len <= h_cnt+1.
  - On vs_fall: frame_lines <= v_cnt+1.
  - Both update in every state.
- FSM states: SEARCH, ACQUIRE, LOCKED. locked=1 only in LOCKED.
- SEARCH:
  - No checks performed.
  - vs_fall -> ACQUIRE, good_cnt=0, frame_bad=0.
- ACQUIRE and LOCKED share the same checks. Each of the following is a violation:
  - hs_fall with h_cnt+1 != H_TOTAL.
  - hs_rise with h_cnt+1 != H_SYNC.
  - vs_fall with v_cnt+1 != V_TOTAL.
- On a violation:
  - sync_err pulses for one clk.
  - Next state is ACQUIRE, good_cnt=0, frame_bad=1, locked=0 on the next clk.
  - If the violation is itself a vs_fall, frame_bad is set to 0 instead, because a new frame starts.
- Clean vs_fall in ACQUIRE:
  - frame_bad=1: clear frame_bad, do not count the frame.
  - frame_bad=0: good_cnt++. When good_cnt reaches LOCK_FRAMES -> LOCKED.
- Loss of sync:
  - h_cnt reaching 1023, or v_cnt reaching 1023, in any state -> SEARCH.
  - locked deasserts and sync_err pulses once.
- Simultaneous violations on the same tick produce a single sync_err pulse.
- pix_ce=0: no register changes. sync_err stays 0.

Test Plan:
- Nominal 800x521 stream, pix_ce every 2nd clk, starting mid-frame:
  - SEARCH until the first VS fall, then locked=1 on the tick of the 2nd clean VS fall after that.
  - After lock, each frame has exactly 307200 de ticks.
  - First de sample per frame: vga_xypos={11'd0,10'd0} at h_cnt=144, v_cnt=31.
  - Last de sample per frame: {11'd639,10'd479}.
  - line_len=800, frame_lines=521.
- While locked, inject one 799-sample line:
  - sync_err pulses once, locked=0 on the next clk, line_len=799.
  - The remainder of that frame is not counted; locked=1 again after 2 further clean frames.
- While locked, make HS low for 95 samples:
  - sync_err pulses on the HS rise, locked drops.
- Hold HS and VS high for 1100 samples:
  - Within 1023 samples, state=SEARCH, locked=0, de=0, sync_err pulses once.
- Assert rst mid-frame while locked:
  - On the next clk all outputs are 0; reacquisition after the first VS fall plus 2 clean frames.
- Stall pix_ce low for 50 clks mid-line:
  - Counters and outputs are unchanged, no sync_err, lock is held.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Receive side of the 640x480 VGA timing. Samples an incoming active-low
// HS/VS plus 3-bit RGB stream on pix_ce and recovers the pixel position and
// data-enable. Measures line and frame lengths, and declares lock once the
// timing has matched the expected format for LOCK_FRAMES clean frames.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active high
//   pix_ce       pixel sample strobe; state advances only on clk edges with pix_ce=1
//   vga_hs       horizontal sync, active low
//   vga_vs       vertical sync, active low
//   vga_rgb      incoming colour
//   rgb_out      registered colour, 0 outside the active area
//   de           active-pixel flag
//   vga_xypos    {x[10:0], y[9:0]}, meaningful only while de=1
//   locked       timing lock
//   sync_err     one-clk pulse on any timing violation or loss of sync
//   line_len     sample count of the last completed line
//   frame_lines  line count of the last completed frame
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_DISP      = 640,
  parameter int V_TOTAL     = 521,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 29,
  parameter int V_DISP      = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [2:0]  vga_rgb,
  output logic [2:0]  rgb_out,
  output logic        de,
  output logic [20:0] vga_xypos,
  output logic        locked,
  output logic        sync_err,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0]  CNT_MAX   = 10'd1023;
  localparam logic [9:0]  H_LEN     = 10'(H_TOTAL);
  localparam logic [9:0]  HS_LEN    = 10'(H_SYNC);
  localparam logic [9:0]  V_LEN     = 10'(V_TOTAL);
  localparam logic [9:0]  H_START   = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_END     = 10'(H_SYNC + H_BP + H_DISP);
  localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BP + V_DISP);
  localparam logic [10:0] X_OFS     = 11'(H_SYNC + H_BP);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t              state, state_nxt;
  logic                hs_d, vs_d;
  logic [9:0]          h_cnt, v_cnt, h_nxt, v_nxt;
  logic [GOOD_W-1:0]   good_cnt, good_nxt;
  logic                frame_bad, frame_bad_nxt;
  logic                hs_fall, hs_rise, vs_fall;
  logic                viol, lost, active;
  logic [10:0]         x_nxt;
  logic [9:0]          y_nxt;

  assign hs_fall = hs_d & ~vga_hs;
  assign hs_rise = ~hs_d & vga_hs;
  assign vs_fall = vs_d & ~vga_vs;

  // Position counters as they will be after this sample. Both saturate so a
  // dead input parks them at CNT_MAX instead of wrapping into a fake timing.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (hs_fall) begin
      h_nxt = 10'd0;
    end else if (h_cnt != CNT_MAX) begin
      h_nxt = h_cnt + 10'd1;
    end
    if (vs_fall) begin
      v_nxt = 10'd0;
    end else if (hs_fall && (v_cnt != CNT_MAX)) begin
      v_nxt = v_cnt + 10'd1;
    end
  end

  // Loss of sync fires only on the sample a counter first hits saturation,
  // so a stalled input produces a single error pulse.
  assign lost = ((h_nxt == CNT_MAX) && (h_cnt != CNT_MAX)) ||
                ((v_nxt == CNT_MAX) && (v_cnt != CNT_MAX));

  // Timing checks: the counters still hold the last value of the finishing
  // line/pulse/frame, so count+1 is its measured length.
  assign viol = (state != SEARCH) &&
                ((hs_fall && ((h_cnt + 10'd1) != H_LEN)) ||
                 (hs_rise && ((h_cnt + 10'd1) != HS_LEN)) ||
                 (vs_fall && ((v_cnt + 10'd1) != V_LEN)));

  // Lock FSM. Loss of sync overrides everything; a violation restarts
  // acquisition, and the partial frame after it is discarded unless the
  // violation was itself a frame start.
  always_comb begin
    state_nxt     = state;
    good_nxt      = good_cnt;
    frame_bad_nxt = frame_bad;
    if (lost) begin
      state_nxt = SEARCH;
    end else begin
      case (state)
        SEARCH: begin
          if (vs_fall) begin
            state_nxt     = ACQUIRE;
            good_nxt      = '0;
            frame_bad_nxt = 1'b0;
          end
        end
        ACQUIRE, LOCKED: begin
          if (viol) begin
            state_nxt     = ACQUIRE;
            good_nxt      = '0;
            frame_bad_nxt = ~vs_fall;
          end else if (vs_fall && (state == ACQUIRE)) begin
            if (frame_bad) begin
              frame_bad_nxt = 1'b0;
            end else begin
              good_nxt = good_cnt + GOOD_W'(1);
              if (good_cnt == GOOD_LAST) begin
                state_nxt = LOCKED;
              end
            end
          end
        end
        default: begin
          state_nxt = SEARCH;
        end
      endcase
    end
  end

  // de is qualified with the post-sample lock state so de and locked always
  // agree on the same output cycle.
  assign active = (state_nxt == LOCKED) &&
                  (h_nxt >= H_START) && (h_nxt < H_END) &&
                  (v_nxt >= V_START) && (v_nxt < V_END);
  assign x_nxt  = {1'b0, h_nxt} - X_OFS;
  assign y_nxt  = v_nxt - V_START;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      state       <= SEARCH;
      good_cnt    <= '0;
      frame_bad   <= 1'b0;
      rgb_out     <= 3'd0;
      de          <= 1'b0;
      vga_xypos   <= 21'd0;
      sync_err    <= 1'b0;
      line_len    <= 10'd0;
      frame_lines <= 10'd0;
    end else begin
      sync_err <= 1'b0;
      if (pix_ce) begin
        hs_d      <= vga_hs;
        vs_d      <= vga_vs;
        h_cnt     <= h_nxt;
        v_cnt     <= v_nxt;
        state     <= state_nxt;
        good_cnt  <= good_nxt;
        frame_bad <= frame_bad_nxt;
        de        <= active;
        vga_xypos <= {x_nxt, y_nxt};
        rgb_out   <= active ? vga_rgb : 3'd0;
        sync_err  <= lost | viol;
        if (hs_fall) begin
          line_len <= h_cnt + 10'd1;
        end
        if (vs_fall) begin
          frame_lines <= v_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
// Drives a reduced-size VGA-style raster into vga_sync_decoder with pix_ce on
// every second clock. The bench tracks the transmitter's raster position and
// the frame count since the last disturbance, and from those derives the
// expected lock, de, position, colour, line and frame length.
module tb_vga_sync_decoder;

  localparam int H_TOTAL     = 40;
  localparam int H_SYNC      = 4;
  localparam int H_BP        = 3;
  localparam int H_DISP      = 30;
  localparam int V_TOTAL     = 12;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 2;
  localparam int V_DISP      = 7;
  localparam int LOCK_FRAMES = 2;
  localparam int H_START     = H_SYNC + H_BP;
  localparam int V_START     = V_SYNC + V_BP;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic        vga_hs;
  logic        vga_vs;
  logic [2:0]  vga_rgb;
  logic [2:0]  rgb_out;
  logic        de;
  logic [20:0] vga_xypos;
  logic        locked;
  logic        sync_err;
  logic [9:0]  line_len;
  logic [9:0]  frame_lines;

  int tests = 0;
  int failures = 0;

  // Transmitter raster position of the next sample to send.
  int gx, gy;
  // Frame starts sent so far, and the frame start at which lock is due.
  int vs_count, lock_vs;
  // 0: none, 1: shorten line fault_line by one sample, 2: one-sample-short HS on fault_line.
  int fault_kind, fault_line;
  bit pend_short;
  bit line_ok, frame_ok, frame_full;
  int de_count;
  bit          exp_de;
  logic [20:0] exp_xy;
  logic [2:0]  exp_rgb;

  vga_sync_decoder #(
    .H_TOTAL    (H_TOTAL),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .H_DISP     (H_DISP),
    .V_TOTAL    (V_TOTAL),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP),
    .V_DISP     (V_DISP),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_rgb    (vga_rgb),
    .rgb_out    (rgb_out),
    .de         (de),
    .vga_xypos  (vga_xypos),
    .locked     (locked),
    .sync_err   (sync_err),
    .line_len   (line_len),
    .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  // Hard stop in case the stimulus never completes.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One idle clock with garbage inputs (must be ignored), then one sampling clock.
  task automatic apply_stimulus(input logic hs, input logic vs, input logic [2:0] rgb);
    vga_hs  = 1'($urandom);
    vga_vs  = 1'($urandom);
    vga_rgb = 3'($urandom);
    pix_ce  = 1'b0;
    @(posedge clk);
    #1;
    check_output("idle_sync_err", sync_err, 0);
    vga_hs  = hs;
    vga_vs  = vs;
    vga_rgb = rgb;
    pix_ce  = 1'b1;
    @(posedge clk);
    #1;
    pix_ce = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_output("rst_rgb_out", rgb_out, 0);
    check_output("rst_de", de, 0);
    check_output("rst_xypos", vga_xypos, 0);
    check_output("rst_locked", locked, 0);
    check_output("rst_sync_err", sync_err, 0);
    check_output("rst_line_len", line_len, 0);
    check_output("rst_frame_lines", frame_lines, 0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pix_ce  = 1'b1;
    vga_hs  = 1'($urandom);
    vga_vs  = 1'($urandom);
    vga_rgb = 3'($urandom);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    pix_ce = 1'b0;
    check_reset_outputs();
  endtask

  // Send the next raster sample and check every output against the raster position.
  task automatic stream_sample();
    logic       hs, vs;
    logic [2:0] rgb;
    bit         err, short_fall, exp_locked, active;
    hs         = (gx >= H_SYNC);
    vs         = (gy >= V_SYNC);
    short_fall = pend_short;
    pend_short = 1'b0;
    err        = short_fall;
    if (fault_kind == 2 && gy == fault_line && gx == H_SYNC - 1) begin
      hs         = 1'b1;
      err        = 1'b1;
      fault_kind = 0;
    end
    rgb = 3'($urandom);
    apply_stimulus(hs, vs, rgb);

    if (gx == 0 && gy == 0) vs_count++;
    // After a violation: next frame start discards the damaged frame, then LOCK_FRAMES clean ones.
    if (err) lock_vs = vs_count + 1 + LOCK_FRAMES;
    exp_locked = (vs_count >= lock_vs);
    active = exp_locked && gx >= H_START && gx < H_START + H_DISP &&
             gy >= V_START && gy < V_START + V_DISP;

    check_output("sync_err", sync_err, err);
    check_output("locked", locked, exp_locked);
    check_output("de", de, active);
    check_output("rgb_out", rgb_out, active ? rgb : 3'd0);
    exp_de  = active;
    exp_xy  = {11'(gx - H_START), 10'(gy - V_START)};
    exp_rgb = active ? rgb : 3'd0;
    if (active) check_output("xypos", vga_xypos, exp_xy);

    if (gx == 0) begin
      if (line_ok) check_output("line_len", line_len, short_fall ? H_TOTAL - 1 : H_TOTAL);
      line_ok = 1'b1;
    end
    if (gx == 0 && gy == 0) begin
      if (frame_ok) check_output("frame_lines", frame_lines, V_TOTAL);
      frame_ok = 1'b1;
      if (frame_full) check_output("de_per_frame", de_count, H_DISP * V_DISP);
      de_count   = 0;
      frame_full = exp_locked;
    end
    if (!exp_locked) frame_full = 1'b0;
    if (de === 1'b1) de_count++;

    gx++;
    if (fault_kind == 1 && gy == fault_line && gx == H_TOTAL - 1) begin
      pend_short = 1'b1;
      fault_kind = 0;
      gx = 0;
      gy = (gy + 1) % V_TOTAL;
    end else if (gx == H_TOTAL) begin
      gx = 0;
      gy = (gy + 1) % V_TOTAL;
    end
  endtask

  task automatic run_frames(input int n);
    int target = vs_count + n;
    int budget = (n + 1) * H_TOTAL * V_TOTAL + 10;
    while (vs_count < target && budget > 0) begin
      stream_sample();
      budget--;
    end
    check_output("frame_budget", (vs_count >= target), 1);
  endtask

  // Advance a random distance, then to a line where VS is high and not the last line.
  task automatic run_to_mid_frame();
    int extra = $urandom_range(10, H_TOTAL * V_TOTAL / 2);
    for (int i = 0; i < extra; i++) stream_sample();
    for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
      if (gy >= V_SYNC && gy <= V_TOTAL - 2) break;
      stream_sample();
    end
  endtask

  task automatic restart_expectations();
    lock_vs    = vs_count + 1 + LOCK_FRAMES;
    line_ok    = 1'b0;
    frame_ok   = 1'b0;
    frame_full = 1'b0;
  endtask

  initial begin
    int err_seen;
    int budget;
    rst     = 1'b0;
    pix_ce  = 1'b0;
    vga_hs  = 1'b1;
    vga_vs  = 1'b1;
    vga_rgb = 3'd0;
    fault_kind = 0;
    fault_line = 0;
    pend_short = 1'b0;
    de_count   = 0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] power-on reset");
    do_reset();

    $display("[TB] nominal stream from mid-frame");
    gx = $urandom_range(0, H_TOTAL - 1);
    gy = $urandom_range(V_SYNC, V_TOTAL - 1);
    vs_count = 0;
    restart_expectations();
    run_frames(5);
    check_output("nominal_locked", locked, 1);

    $display("[TB] short line while locked");
    fault_line = $urandom_range(1, V_TOTAL - 2);
    fault_kind = 1;
    run_frames(1);
    check_output("short_line_unlocked", locked, 0);
    run_frames(LOCK_FRAMES + 2);
    check_output("short_line_relocked", locked, 1);

    $display("[TB] short HS pulse while locked");
    fault_line = $urandom_range(1, V_TOTAL - 2);
    fault_kind = 2;
    run_frames(1);
    check_output("short_hs_unlocked", locked, 0);
    run_frames(LOCK_FRAMES + 2);
    check_output("short_hs_relocked", locked, 1);

    $display("[TB] pix_ce stall inside the active area");
    budget = 2 * H_TOTAL * V_TOTAL;
    for (int i = 0; i < $urandom_range(0, 200); i++) stream_sample();
    while (!(exp_de && gx < H_START + H_DISP - 2) && budget > 0) begin
      stream_sample();
      budget--;
    end
    check_output("stall_found_active", exp_de, 1);
    for (int i = 0; i < 50; i++) begin
      vga_hs  = 1'($urandom);
      vga_vs  = 1'($urandom);
      vga_rgb = 3'($urandom);
      pix_ce  = 1'b0;
      @(posedge clk);
      #1;
      check_output("stall_sync_err", sync_err, 0);
      check_output("stall_locked", locked, 1);
      check_output("stall_de", de, exp_de);
      check_output("stall_xypos", vga_xypos, exp_xy);
      check_output("stall_rgb_out", rgb_out, exp_rgb);
    end
    run_frames(2);
    check_output("stall_still_locked", locked, 1);

    $display("[TB] HS and VS held high");
    run_to_mid_frame();
    err_seen = 0;
    for (int i = 0; i < 1100; i++) begin
      apply_stimulus(1'b1, 1'b1, 3'($urandom));
      if (sync_err === 1'b1) err_seen++;
      if (i == 1022) check_output("hold_locked_by_1023", locked, 0);
    end
    check_output("hold_err_pulses", err_seen, 1);
    check_output("hold_locked", locked, 0);
    check_output("hold_de", de, 0);
    restart_expectations();
    run_frames(LOCK_FRAMES + 3);
    check_output("hold_relocked", locked, 1);

    $display("[TB] reset mid-frame while locked");
    run_to_mid_frame();
    check_output("pre_reset_locked", locked, 1);
    do_reset();
    restart_expectations();
    run_frames(LOCK_FRAMES + 3);
    check_output("reset_relocked", locked, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
